pc_exc_unit: RTL and testbench

- Program-counter and exception-sequencing unit for the multicycle MIPS datapath.
- Owns the PC, EPC and CAUSE registers, and the PC-source selection.
- Contains a small FSM that, on an exception request, saves the return address, records the cause, reads the handler byte from the vector table in memory and redirects the PC.
- Sits between the control unit, the ALU/ALUOut path and the memory address mux.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/pc_exc_unit_if.sv | 34 +++
 rtl/exc_prio_enc.sv | 20 ++
 rtl/registrador.sv | 15 +
 rtl/pc_exc_unit.sv | 126 ++++++++++++
 tb/tb_pc_exc_unit.sv | 189 ++++++++++++++++++
 6 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS PC/exception logic.
// PC_ALIGN_CHECK_EN adds an internal misaligned-PC cause and widens the cause field.
package mips_pkg;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_EPC    = 2'd3;

    localparam int CAUSE_OPCODE = 0;
    localparam int CAUSE_OVF    = 1;
    localparam int CAUSE_DIV0   = 2;

    localparam int DEFAULT_VEC_BASE = 253;

`ifdef PC_ALIGN_CHECK_EN
    localparam int ALIGN_EXTRA = 1;
`else
    localparam int ALIGN_EXTRA = 0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        VEC_RD,
        VEC_WAIT,
        LOAD
    } exc_state_e;

    // Index bits plus one valid MSB; the index must also reach the internal align cause.
    function automatic int cause_width(input int n);
        int iw;
        iw = $clog2(n + ALIGN_EXTRA);
        if (iw < 1) iw = 1;
        return iw + 1;
    endfunction

endpackage

// File: rtl/pc_exc_unit_if.sv
// Control/bus bundle between the control unit, datapath and pc_exc_unit.
interface pc_exc_unit_if #(
    parameter int WIDTH      = 32,
    parameter int NUM_CAUSES = 3,
    parameter int CW         = mips_pkg::cause_width(NUM_CAUSES)
) ();
    logic                  pc_write;
    logic                  pc_write_cond;
    logic                  branch_taken;
    logic [1:0]            pc_src;
    logic [WIDTH-1:0]      alu_result;
    logic [WIDTH-1:0]      alu_out;
    logic [25:0]           instr_index;
    logic [NUM_CAUSES-1:0] exc_req;
    logic                  vec_rd_req;
    logic [WIDTH-1:0]      vec_addr;
    logic [7:0]            vec_rd_data;
    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      epc;
    logic [CW-1:0]         cause;
    logic                  exc_busy;

    modport slave (
        input  pc_write, pc_write_cond, branch_taken, pc_src, alu_result, alu_out,
               instr_index, exc_req, vec_rd_data,
        output vec_rd_req, vec_addr, pc, epc, cause, exc_busy
    );

    modport master (
        output pc_write, pc_write_cond, branch_taken, pc_src, alu_result, alu_out,
               instr_index, exc_req, vec_rd_data,
        input  vec_rd_req, vec_addr, pc, epc, cause, exc_busy
    );
endinterface

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder for exception requests.
module exc_prio_enc #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IW'(i);
                o_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/registrador.sv
// Generic load-enable register with asynchronous active-low clear.
module registrador #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_ld,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    o_q <= '0;
        else if (i_ld) o_q <= i_d;
    end
endmodule

// File: rtl/pc_exc_unit.sv
// PC / EPC / CAUSE ownership and exception entry sequencing (save, vector fetch, redirect).
// Optional: PC_ALIGN_CHECK_EN traps misaligned PC loads as lowest-priority internal cause.
module pc_exc_unit
    import mips_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_CAUSES = 3,
    parameter int VEC_BASE   = DEFAULT_VEC_BASE,
    parameter int MEM_LAT    = 1
) (
    input  logic         clk,
    input  logic         reset,
    pc_exc_unit_if.slave bus
);
    localparam int CW = cause_width(NUM_CAUSES);
    localparam int IW = CW - 1;

    exc_state_e       r_state, w_next;
    logic [IW-1:0]    r_idx;
    logic [2:0]       r_cnt;
    logic [7:0]       r_vec_data;
    logic [WIDTH-1:0] r_vec_addr;

    logic [WIDTH-1:0] w_pc, w_sel, w_jump, w_pc_d;
    logic [IW-1:0]    w_req_idx, w_exc_idx;
    logic             w_req_vld, w_pc_ld_req, w_misalign;
    logic             w_pc_ld, w_save, w_vec_req;

    exc_prio_enc #(.N(NUM_CAUSES), .IW(IW)) u_enc (
        .i_req (bus.exc_req),
        .o_idx (w_req_idx),
        .o_vld (w_req_vld)
    );

    assign w_jump = {w_pc[WIDTH-1:28], bus.instr_index, 2'b00};

    always_comb begin
        w_sel = bus.alu_result;
        case (bus.pc_src)
            PC_SRC_ALU:    w_sel = bus.alu_result;
            PC_SRC_ALUOUT: w_sel = bus.alu_out;
            PC_SRC_JUMP:   w_sel = w_jump;
            PC_SRC_EPC:    w_sel = bus.epc;
            default:       w_sel = bus.alu_result;
        endcase
    end

    assign w_pc_ld_req = bus.pc_write | (bus.pc_write_cond & bus.branch_taken);

`ifdef PC_ALIGN_CHECK_EN
    assign w_misalign = w_pc_ld_req & (w_sel[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // External requests outrank the internal alignment trap.
    assign w_exc_idx = w_req_vld ? w_req_idx : IW'(NUM_CAUSES);

    always_comb begin
        w_next    = r_state;
        w_pc_ld   = 1'b0;
        w_pc_d    = w_sel;
        w_save    = 1'b0;
        w_vec_req = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_vld || w_misalign) w_next = SAVE;
                else if (w_pc_ld_req)        w_pc_ld = 1'b1;
            end
            SAVE: begin
                w_save = 1'b1;
                w_next = VEC_RD;
            end
            VEC_RD: begin
                w_vec_req = 1'b1;
                w_next    = VEC_WAIT;
            end
            VEC_WAIT: begin
                if (r_cnt <= 3'd1) w_next = LOAD;
            end
            LOAD: begin
                w_pc_ld = 1'b1;
                w_pc_d  = WIDTH'(r_vec_data);
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_vec_data <= '0;
            r_vec_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == SAVE) r_idx <= w_exc_idx;
            if (r_state == VEC_RD) begin
                r_cnt <= 3'(MEM_LAT);
            end else if (r_state == VEC_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt <= 3'd1) r_vec_data <= bus.vec_rd_data;
            end
            if (w_save) r_vec_addr <= WIDTH'(VEC_BASE) + WIDTH'(r_idx);
        end
    end

    registrador #(.W(WIDTH)) u_pc (
        .clk(clk), .reset(reset), .i_ld(w_pc_ld), .i_d(w_pc_d), .o_q(w_pc)
    );

    registrador #(.W(WIDTH)) u_epc (
        .clk(clk), .reset(reset), .i_ld(w_save), .i_d(w_pc - WIDTH'(4)), .o_q(bus.epc)
    );

    registrador #(.W(CW)) u_cause (
        .clk(clk), .reset(reset), .i_ld(w_save), .i_d({1'b1, r_idx}), .o_q(bus.cause)
    );

    assign bus.pc         = w_pc;
    assign bus.vec_addr   = r_vec_addr;
    assign bus.vec_rd_req = w_vec_req;
    assign bus.exc_busy   = (r_state != IDLE);
endmodule

// File: tb/tb_pc_exc_unit.sv
// Directed-vector bench for pc_exc_unit (WIDTH=32, NUM_CAUSES=3, VEC_BASE=253, MEM_LAT=1).
module tb_pc_exc_unit;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    pc_exc_unit_if #(.WIDTH(32), .NUM_CAUSES(3)) bus ();

    pc_exc_unit #(.WIDTH(32), .NUM_CAUSES(3), .VEC_BASE(253), .MEM_LAT(1)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.pc_src        = 2'd0;
        bus.alu_result    = '0;
        bus.alu_out       = '0;
        bus.instr_index   = '0;
        bus.exc_req       = '0;
        bus.vec_rd_data   = '0;
        tick();
        tick();

        chk("rst_pc",       64'(bus.pc),         64'h0);
        chk("rst_epc",      64'(bus.epc),        64'h0);
        chk("rst_cause",    64'(bus.cause),      64'h0);
        chk("rst_vec_req",  64'(bus.vec_rd_req), 64'h0);
        chk("rst_vec_addr", 64'(bus.vec_addr),   64'h0);
        chk("rst_busy",     64'(bus.exc_busy),   64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Unconditional PC write from the ALU result
        bus.pc_write = 1'b1; bus.pc_src = 2'd0; bus.alu_result = 32'h4;
        tick();
        chk("pcw_alu",  64'(bus.pc),       64'h4);
        chk("pcw_busy", 64'(bus.exc_busy), 64'h0);
        bus.pc_write = 1'b0;

        // Conditional write: not taken, then taken
        bus.pc_write_cond = 1'b1; bus.branch_taken = 1'b0; bus.pc_src = 2'd1; bus.alu_out = 32'h40;
        tick();
        chk("br_not_taken", 64'(bus.pc), 64'h4);
        bus.branch_taken = 1'b1;
        tick();
        chk("br_taken", 64'(bus.pc), 64'h40);
        bus.pc_write_cond = 1'b0; bus.branch_taken = 1'b0;

        // Jump: {pc[31:28]=0, 0x400, 00} = 0x1000
        bus.instr_index = 26'h400; bus.pc_src = 2'd2; bus.pc_write = 1'b1;
        tick();
        chk("jump", 64'(bus.pc), 64'h1000);
        bus.pc_write = 1'b0;

        // Exception 3'b110 -> index 1; competing pc_write must be ignored
        bus.exc_req = 3'b110; bus.vec_rd_data = 8'h7C;
        bus.pc_write = 1'b1; bus.pc_src = 2'd0; bus.alu_result = 32'h8;
        tick();
        chk("exc_save_busy", 64'(bus.exc_busy),   64'h1);
        chk("exc_pc_held",   64'(bus.pc),         64'h1000);
        chk("exc_no_req_s",  64'(bus.vec_rd_req), 64'h0);
        bus.exc_req = 3'b000; bus.pc_write = 1'b0;
        tick();
        chk("exc_epc",      64'(bus.epc),        64'hFFC);
        chk("exc_cause",    64'(bus.cause),      64'h5);
        chk("exc_vec_addr", 64'(bus.vec_addr),   64'd254);
        chk("exc_vec_req",  64'(bus.vec_rd_req), 64'h1);
        chk("exc_rd_busy",  64'(bus.exc_busy),   64'h1);
        bus.exc_req = 3'b001;
        tick();
        chk("exc_req_1cyc",  64'(bus.vec_rd_req), 64'h0);
        chk("exc_wait_busy", 64'(bus.exc_busy),   64'h1);
        chk("exc_wait_pc",   64'(bus.pc),         64'h1000);
        bus.exc_req = 3'b000;
        tick();
        chk("exc_load_busy", 64'(bus.exc_busy), 64'h1);
        chk("exc_load_pc",   64'(bus.pc),       64'h1000);
        tick();
        chk("exc_new_pc",    64'(bus.pc),       64'h7C);
        chk("exc_done_busy", 64'(bus.exc_busy), 64'h0);
        chk("vec_addr_hold", 64'(bus.vec_addr), 64'd254);
        tick();
        tick();
        chk("busy_req_ignored", 64'(bus.exc_busy), 64'h0);
        chk("cause_kept",       64'(bus.cause),    64'h5);
        chk("pc_kept",          64'(bus.pc),       64'h7C);

        // ERET restores pc from epc; cause untouched
        bus.pc_src = 2'd3; bus.pc_write = 1'b1;
        tick();
        chk("eret_pc",    64'(bus.pc),    64'hFFC);
        chk("eret_cause", 64'(bus.cause), 64'h5);
        bus.pc_write = 1'b0;

        // pc=0 then exception 0: epc wraps
        bus.pc_src = 2'd0; bus.alu_result = 32'h0; bus.pc_write = 1'b1;
        tick();
        chk("pc_zero", 64'(bus.pc), 64'h0);
        bus.pc_write = 1'b0; bus.exc_req = 3'b001; bus.vec_rd_data = 8'h55;
        tick();
        bus.exc_req = 3'b000;
        tick();
        chk("wrap_epc",      64'(bus.epc),      64'hFFFF_FFFC);
        chk("wrap_vec_addr", 64'(bus.vec_addr), 64'd253);
        chk("wrap_cause",    64'(bus.cause),    64'h4);
        tick();
        chk("in_vec_wait", 64'(bus.exc_busy), 64'h1);

        // Async reset in VEC_WAIT
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_epc",      64'(bus.epc),        64'h0);
        chk("arst_cause",    64'(bus.cause),      64'h0);
        chk("arst_vec_addr", 64'(bus.vec_addr),   64'h0);
        chk("arst_busy",     64'(bus.exc_busy),   64'h0);
        chk("arst_vec_req",  64'(bus.vec_rd_req), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_idle_busy", 64'(bus.exc_busy), 64'h0);
        chk("arst_pc_stays",  64'(bus.pc),       64'h0);

        // Misaligned target
        bus.pc_src = 2'd0; bus.alu_result = 32'h6; bus.pc_write = 1'b1; bus.vec_rd_data = 8'h20;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        chk("align_pc_held", 64'(bus.pc),       64'h0);
        chk("align_busy",    64'(bus.exc_busy), 64'h1);
        bus.pc_write = 1'b0;
        tick();
        chk("align_vec_addr", 64'(bus.vec_addr), 64'd256);
        chk("align_cause",    64'(bus.cause),    64'h7);
        chk("align_epc",      64'(bus.epc),      64'hFFFF_FFFC);
        tick();
        tick();
        tick();
        chk("align_new_pc", 64'(bus.pc), 64'h20);
`else
        chk("misalign_loaded", 64'(bus.pc),       64'h6);
        chk("misalign_busy",   64'(bus.exc_busy), 64'h0);
        bus.pc_write = 1'b0;
`endif

        // Highest single cause index -> VEC_BASE+2
        bus.exc_req = 3'b100;
        tick();
        bus.exc_req = 3'b000;
        tick();
        chk("cause2_vec_addr", 64'(bus.vec_addr), 64'd255);
        chk("cause2_cause",    64'(bus.cause),    64'h6);
        tick();
        tick();
        tick();
        chk("cause2_pc",   64'(bus.pc),       64'h20);
        chk("cause2_idle", 64'(bus.exc_busy), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
